stopwatch_counter: RTL and testbench

Parametrised successor of the lab 3 minutes:seconds counter. It is a single-clock BCD stopwatch that advances on one-cycle tick enables instead of derived clocks, and it has a small state machine for run, pause, adjust and (optionally) countdown expiry. It sits between the tick divider and the seven-segment display mux. It drives four BCD digits, a state code the display uses for blinking, and a wrap pulse.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/bcd_digit.sv | 29 ++
 rtl/stopwatch_counter.sv | 129 ++++++++++++
 tb/tb_stopwatch_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and limits for the BCD stopwatch.
// Latency: n/a (constants only). Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_ADJ     = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single mod-(max_val+1) BCD digit with increment/decrement enables and carry/borrow out.
// Latency: 1 cycle from enable to digit update. Backpressure: none, enables act immediately.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] q,
  output logic               carry,
  output logic               borrow
);

  assign carry  = inc && (q == max_val);
  assign borrow = dec && (q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc) begin
      q <= carry ? '0 : q + DIGIT_W'(1);
    end else if (dec) begin
      q <= borrow ? max_val : q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause/adjust FSM; STOPWATCH_COUNTDOWN_EN adds down count and expiry.
// Latency: digits, wrap and expired update 1 cycle after the sampled tick; state changes 1 edge after cause.
// Backpressure: none; tick enables not used by the current state are dropped.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX      = 99,
  parameter bit START_PAUSED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               pause_tgl,
  input  logic               adj,
  input  logic               sel,
  input  logic               dir,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [1:0]         state,
  output logic               wrap,
  output logic               expired
);

  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = DIGIT_W'(MIN_MAX / 10);
  localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = DIGIT_W'(MIN_MAX % 10);
  localparam logic [DIGIT_W-1:0] DEC_MAX      = 4'd9;
  localparam state_t             RST_STATE    = START_PAUSED ? ST_PAUSE : ST_RUN;

  state_t state_q, state_d;
  logic   run_flag_q;
  logic   wrap_q;
  logic   down;
  logic   at_low, at_zero;
  logic   count_up, count_dn, adj_sec, adj_min;
  logic   so_c, so_b, st_c, st_b, mo_c, mo_b, mt_c, mt_b;
  logic [DIGIT_W-1:0] min_ones_max;

`ifdef STOPWATCH_COUNTDOWN_EN
  logic expired_q;

  assign down = dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) expired_q <= 1'b0;
    else     expired_q <= (state_d == ST_EXPIRED);
  end

  assign expired = expired_q;
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign down       = 1'b0;
  assign expired    = 1'b0;
`endif

  assign at_low  = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) &&
                   (sec_ones <= DIGIT_W'(1));
  assign at_zero = at_low && (sec_ones == '0);

  assign count_up = (state_q == ST_RUN) && tick_1hz && !down;
  assign count_dn = (state_q == ST_RUN) && tick_1hz && down && !at_zero;
  assign adj_sec  = (state_q == ST_ADJ) && tick_2hz && sel;
  assign adj_min  = (state_q == ST_ADJ) && tick_2hz && !sel;

  // Minutes ones wraps early only in the top decade; a borrow always reloads 9.
  assign min_ones_max = (count_dn || (min_tens != MIN_TENS_MAX)) ? DEC_MAX : MIN_ONES_MAX;

  bcd_digit u_sec_ones (
    .clk(clk), .rst(rst), .inc(count_up || adj_sec), .dec(count_dn),
    .max_val(SEC_ONES_MAX), .q(sec_ones), .carry(so_c), .borrow(so_b)
  );

  bcd_digit u_sec_tens (
    .clk(clk), .rst(rst), .inc(so_c), .dec(so_b),
    .max_val(SEC_TENS_MAX), .q(sec_tens), .carry(st_c), .borrow(st_b)
  );

  bcd_digit u_min_ones (
    .clk(clk), .rst(rst), .inc((st_c && count_up) || adj_min), .dec(st_b),
    .max_val(min_ones_max), .q(min_ones), .carry(mo_c), .borrow(mo_b)
  );

  bcd_digit u_min_tens (
    .clk(clk), .rst(rst), .inc(mo_c), .dec(mo_b),
    .max_val(MIN_TENS_MAX), .q(min_tens), .carry(mt_c), .borrow(mt_b)
  );

  // Down count stops at 00:00, so the minutes tens never borrows.
  logic unused_mt_b;
  assign unused_mt_b = mt_b;

  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = ST_ADJ;
    end else begin
      case (state_q)
        ST_ADJ:     state_d = run_flag_q ? ST_RUN : ST_PAUSE;
        ST_RUN: begin
          if (!run_flag_q)                   state_d = ST_PAUSE;
          else if (down && tick_1hz && at_low) state_d = ST_EXPIRED;
        end
        ST_PAUSE:   if (run_flag_q) state_d = ST_RUN;
        ST_EXPIRED: if (!down) state_d = run_flag_q ? ST_RUN : ST_PAUSE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      run_flag_q <= ~START_PAUSED;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_flag_q <= run_flag_q ^ pause_tgl;
      wrap_q     <= mt_c && count_up;
    end
  end

  assign state = state_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Two stopwatch instances (MIN_MAX 99 and 2) against a seconds-total reference model.
// Directed scenarios first, then randomized ticks, toggles and mode levels.
module tb_stopwatch_counter;

`ifdef STOPWATCH_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tick_1hz, tick_2hz, pause_tgl, adj, sel, dir;
  logic [3:0] mt [2];
  logic [3:0] mo [2];
  logic [3:0] st [2];
  logic [3:0] so [2];
  logic [1:0] stt [2];
  logic       wr [2];
  logic       ex [2];

  int n_chk  = 0;
  int n_pass = 0;

  int mm    [2];
  int m_t   [2];
  bit m_run [2];
  int m_st  [2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  stopwatch_counter #(.MIN_MAX(99), .START_PAUSED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_tgl(pause_tgl), .adj(adj), .sel(sel), .dir(dir),
    .min_tens(mt[0]), .min_ones(mo[0]), .sec_tens(st[0]), .sec_ones(so[0]),
    .state(stt[0]), .wrap(wr[0]), .expired(ex[0])
  );

  stopwatch_counter #(.MIN_MAX(2), .START_PAUSED(1'b0)) dut1 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_tgl(pause_tgl), .adj(adj), .sel(sel), .dir(dir),
    .min_tens(mt[1]), .min_ones(mo[1]), .sec_tens(st[1]), .sec_ones(so[1]),
    .state(stt[1]), .wrap(wr[1]), .expired(ex[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] digits(input int i);
    return {mt[i], mo[i], st[i], so[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i]    = 0;
      m_run[i]  = 1'b1;
      m_st[i]   = 0;
      m_wrap[i] = 1'b0;
    end
  endtask

  // Time is held as total seconds; states as their numeric codes.
  task automatic model_step(input bit t1, t2, pt, a, s, d);
    bit down;
    int tot, told, nst;
    down = CD_EN && d;
    for (int i = 0; i < 2; i++) begin
      tot       = (mm[i] + 1) * 60;
      told      = m_t[i];
      nst       = m_st[i];
      m_wrap[i] = 1'b0;
      if (m_st[i] == 0 && t1) begin
        if (!down) begin
          m_wrap[i] = (told == tot - 1);
          m_t[i]    = (told + 1) % tot;
        end else if (told > 0) begin
          m_t[i] = told - 1;
        end
      end else if (m_st[i] == 2 && t2) begin
        if (s) m_t[i] = (told / 60) * 60 + (told % 60 + 1) % 60;
        else   m_t[i] = ((told / 60 + 1) % (mm[i] + 1)) * 60 + told % 60;
      end
      if (a)                                      nst = 2;
      else if (m_st[i] == 2)                      nst = m_run[i] ? 0 : 1;
      else if (m_st[i] == 0 && !m_run[i])         nst = 1;
      else if (m_st[i] == 1 && m_run[i])          nst = 0;
      else if (m_st[i] == 0 && down && t1 && told <= 1) nst = 3;
      else if (m_st[i] == 3 && !down)             nst = m_run[i] ? 0 : 1;
      m_st[i]  = nst;
      m_run[i] = m_run[i] ^ pt;
    end
  endtask

  task automatic check_all(input string where);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.time%0d", where, i), digits(i), to_bcd(m_t[i]));
      chk($sformatf("%s.state%0d", where, i), stt[i], m_st[i]);
      chk($sformatf("%s.wrap%0d", where, i), wr[i], m_wrap[i]);
      chk($sformatf("%s.expired%0d", where, i), ex[i], (m_st[i] == 3));
    end
  endtask

  task automatic step(input bit t1, t2, pt, a, s, d);
    tick_1hz  = t1;
    tick_2hz  = t2;
    pause_tgl = pt;
    adj       = a;
    sel       = s;
    dir       = d;
    @(posedge clk);
    model_step(t1, t2, pt, a, s, d);
    #1;
    check_all("cyc");
  endtask

  initial begin
    bit a, s, d;
    mm[0] = 99;
    mm[1] = 2;
    tick_1hz = 0; tick_2hz = 0; pause_tgl = 0; adj = 0; sel = 0; dir = 0;
    rst = 1'b1;
    model_reset();
    #23;
    check_all("reset");
    #4 rst = 1'b0;

    repeat (61) step(1, 0, 0, 0, 0, 0);
    chk("t61_time", digits(0), 16'h0101);
    chk("t61_state", stt[0], 2'd0);

    repeat (118) step(1, 0, 0, 0, 0, 0);
    chk("pre_wrap", digits(1), 16'h0259);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap_time", digits(1), 16'h0000);
    chk("wrap_hi", wr[1], 1'b1);
    chk("nowrap_99", wr[0], 1'b0);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_lo", wr[1], 1'b0);

    // Pause coincident with a tick: tick counts, pause follows one edge later.
    step(1, 0, 1, 0, 0, 0);
    chk("pause_tick", digits(0), 16'h0301);
    step(0, 0, 0, 0, 0, 0);
    chk("pause_state", stt[0], 2'd1);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    chk("pause_hold", digits(0), 16'h0301);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("resume", digits(0), 16'h0302);

    step(0, 0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 1, 0, 0);
    chk("adj_min99", digits(0), 16'h0602);
    chk("adj_min2", digits(1), 16'h0002);
    repeat (58) step(0, 1, 0, 1, 1, 0);
    chk("adj_sec_wrap", digits(0), 16'h0600);
    chk("adj_state", stt[0], 2'd2);

    // Asynchronous reset between edges while adjusting.
    #3 rst = 1'b1;
    #1;
    chk("arst_time", digits(0), 16'h0000);
    chk("arst_state", stt[0], 2'd0);
    chk("arst_exp", ex[0], 1'b0);
    model_reset();
    check_all("arst");
    adj = 0; sel = 0; tick_2hz = 0;
    #2 rst = 1'b0;

`ifdef STOPWATCH_COUNTDOWN_EN
    step(0, 0, 0, 1, 1, 0);
    repeat (2) step(0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("cd_start", digits(0), 16'h0002);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("cd_zero", digits(0), 16'h0000);
    chk("cd_state", stt[0], 2'd3);
    chk("cd_expired", ex[0], 1'b1);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    chk("cd_hold", digits(0), 16'h0000);
    step(0, 0, 0, 0, 0, 0);
    chk("cd_leave", stt[0], 2'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("cd_up", digits(0), 16'h0001);
`endif

    a = 0; s = 0; d = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 23) == 0) a = ~a;
      if ($urandom_range(0, 15) == 0) s = ~s;
      if ($urandom_range(0, 39) == 0) d = ~d;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 19) == 0, a, s, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
